// File: rtl/clkroot_div.sv
// Programmable integer clock divider feeding a clock-root anchor; updates only at period boundaries.
// Define CLKDIV_ODD_EN to honour odd divisors; otherwise every divisor is forced even (50% duty).
module clkroot_div #(
    parameter int W         = 8,
    parameter int RESET_DIV = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         div_req_valid,
    input  logic [W-1:0] div_req_data,
    output logic         div_req_ready,
    output logic         clk_div_out,
    output logic         running,
    output logic [W-1:0] cur_div,
    output logic         period_start
);

    typedef enum logic {
        STOPPED,
        RUNNING
    } state_t;

    // Divisors below 2 cannot produce a clock, so they are raised to 2.
    function automatic logic [W-1:0] coerce(input logic [W-1:0] d);
        logic [W-1:0] r;
        r = (d < W'(2)) ? W'(2) : d;
`ifndef CLKDIV_ODD_EN
        r[0] = 1'b0;
`endif
        return r;
    endfunction

    localparam logic [W-1:0] RESET_N = coerce(W'(RESET_DIV));

    state_t       state, state_next;
    logic [W-1:0] ctr, ctr_next;
    logic [W-1:0] cur_div_next;
    logic [W-1:0] pend_div, pend_div_next;
    logic         pend_v, pend_v_next;
    logic         clk_next;
    logic         ps_next;
    logic [W-1:0] ctr_inc;
    logic [W-1:0] half;
    logic         boundary;
    logic         accept;

    assign div_req_ready = !pend_v;
    assign running       = (state == RUNNING);
    assign accept        = div_req_valid && !pend_v;
    assign ctr_inc       = ctr + W'(1);
    assign half          = cur_div >> 1;
    assign boundary      = (ctr == cur_div - W'(1));

    always_comb begin
        state_next    = state;
        ctr_next      = ctr;
        clk_next      = clk_div_out;
        ps_next       = 1'b0;
        cur_div_next  = cur_div;
        pend_div_next = pend_div;
        pend_v_next   = pend_v;

        case (state)
            STOPPED: begin
                ctr_next = '0;
                clk_next = 1'b0;
                if (pend_v) begin
                    cur_div_next = pend_div;
                    pend_v_next  = 1'b0;
                end
                if (en) begin
                    state_next = RUNNING;
                    clk_next   = 1'b1;
                    ps_next    = 1'b1;
                end
            end
            RUNNING: begin
                if (boundary) begin
                    ctr_next = '0;
                    if (pend_v) begin
                        cur_div_next = pend_div;
                        pend_v_next  = 1'b0;
                    end
                    // en is only honoured here so a stop always finishes the full period.
                    if (!en) begin
                        state_next = STOPPED;
                        clk_next   = 1'b0;
                    end else begin
                        clk_next = 1'b1;
                        ps_next  = 1'b1;
                    end
                end else begin
                    ctr_next = ctr_inc;
                    clk_next = (ctr_inc < half);
                end
            end
            default: begin
                state_next = STOPPED;
                ctr_next   = '0;
                clk_next   = 1'b0;
            end
        endcase

        // Accept is only possible with pend_v clear, so it never collides with the apply above;
        // a divisor accepted on a boundary therefore waits for the following boundary.
        if (accept) begin
            pend_div_next = coerce(div_req_data);
            pend_v_next   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= STOPPED;
            ctr          <= '0;
            clk_div_out  <= 1'b0;
            period_start <= 1'b0;
            cur_div      <= RESET_N;
            pend_div     <= RESET_N;
            pend_v       <= 1'b0;
        end else begin
            state        <= state_next;
            ctr          <= ctr_next;
            clk_div_out  <= clk_next;
            period_start <= ps_next;
            cur_div      <= cur_div_next;
            pend_div     <= pend_div_next;
            pend_v       <= pend_v_next;
        end
    end

endmodule

// File: tb/tb_clkroot_div.sv
// Self-checking bench for clkroot_div: vector table for start-up and divisor changes,
// hand-written sequences for odd divisors, small divisors, stop/restart and mid-period reset.
module tb_clkroot_div;

`ifdef CLKDIV_ODD_EN
    localparam logic [7:0] C5 = 8'd5;
`else
    localparam logic [7:0] C5 = 8'd4;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       div_req_valid;
    logic [7:0] div_req_data;
    logic       div_req_ready;
    logic       clk_div_out;
    logic       running;
    logic [7:0] cur_div;
    logic       period_start;

    int checks = 0;
    int errors = 0;

    clkroot_div #(.W(8), .RESET_DIV(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .div_req_valid(div_req_valid),
        .div_req_data (div_req_data),
        .div_req_ready(div_req_ready),
        .clk_div_out  (clk_div_out),
        .running      (running),
        .cur_div      (cur_div),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       valid;
        logic [7:0] data;
        logic       exp_clk;
        logic       exp_ps;
        logic       exp_run;
        logic       exp_rdy;
        logic [7:0] exp_cur;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic [1:0] ins, input logic [7:0] d,
                                input logic [3:0] outs, input logic [7:0] cd);
        vec_t v;
        v.en      = ins[1];
        v.valid   = ins[0];
        v.data    = d;
        v.exp_clk = outs[3];
        v.exp_ps  = outs[2];
        v.exp_run = outs[1];
        v.exp_rdy = outs[0];
        v.exp_cur = cd;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        en            = v.en;
        div_req_valid = v.valid;
        div_req_data  = v.data;
        @(posedge clk);
        #1;
        div_req_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic requestDiv(input logic [7:0] d);
        div_req_valid = 1'b1;
        div_req_data  = d;
        tick();
        div_req_valid = 1'b0;
        checkOutput($sformatf("ready_after_accept_%0d", d), 16'(div_req_ready), 16'd0);
    endtask

    task automatic waitPeriodStart(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            tick();
            if (period_start) seen = 1'b1;
        end
        checkOutput({name, "_period_start_seen"}, 16'(seen), 16'd1);
    endtask

    // Entered just after a period_start edge; ends just after the next one.
    task automatic measurePeriod(input string name, input int exp_high, input int exp_low);
        int  high;
        int  low;
        bit  done;
        high = 1;
        low  = 0;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            tick();
            if (period_start) done = 1'b1;
            else if (clk_div_out) high++;
            else low++;
        end
        checkOutput({name, "_done"}, 16'(done), 16'd1);
        checkOutput({name, "_high"}, 16'(high), 16'(exp_high));
        checkOutput({name, "_low"},  16'(low),  16'(exp_low));
    endtask

    initial begin
        int high;
        int low;
        bit stopped;

        vecs[0]  = mk(2'b10, 8'd0, 4'b1111, 8'd2);
        vecs[1]  = mk(2'b10, 8'd0, 4'b0011, 8'd2);
        vecs[2]  = mk(2'b10, 8'd0, 4'b1111, 8'd2);
        vecs[3]  = mk(2'b10, 8'd0, 4'b0011, 8'd2);
        vecs[4]  = mk(2'b11, 8'd4, 4'b1110, 8'd2);
        vecs[5]  = mk(2'b10, 8'd0, 4'b0010, 8'd2);
        vecs[6]  = mk(2'b10, 8'd0, 4'b1111, 8'd4);
        vecs[7]  = mk(2'b10, 8'd0, 4'b1011, 8'd4);
        vecs[8]  = mk(2'b10, 8'd0, 4'b0011, 8'd4);
        vecs[9]  = mk(2'b11, 8'd6, 4'b0010, 8'd4);
        vecs[10] = mk(2'b10, 8'd0, 4'b1111, 8'd6);
        vecs[11] = mk(2'b10, 8'd0, 4'b1011, 8'd6);
        vecs[12] = mk(2'b10, 8'd0, 4'b1011, 8'd6);
        vecs[13] = mk(2'b11, 8'd5, 4'b0010, 8'd6);
        vecs[14] = mk(2'b10, 8'd0, 4'b0010, 8'd6);
        vecs[15] = mk(2'b10, 8'd0, 4'b0010, 8'd6);
        vecs[16] = mk(2'b10, 8'd0, 4'b1111, C5);

        rst_n         = 1'b0;
        en            = 1'b0;
        div_req_valid = 1'b0;
        div_req_data  = 8'd0;
        #12;
        checkOutput("rst_clk",     16'(clk_div_out),   16'd0);
        checkOutput("rst_running", 16'(running),       16'd0);
        checkOutput("rst_ps",      16'(period_start),  16'd0);
        checkOutput("rst_ready",   16'(div_req_ready), 16'd1);
        checkOutput("rst_cur",     16'(cur_div),       16'd2);
        rst_n = 1'b1;
        tick();
        checkOutput("idle_running", 16'(running),     16'd0);
        checkOutput("idle_clk",     16'(clk_div_out), 16'd0);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_clk", i), 16'(clk_div_out),   16'(vecs[i].exp_clk));
            checkOutput($sformatf("vec%0d_ps", i),  16'(period_start),  16'(vecs[i].exp_ps));
            checkOutput($sformatf("vec%0d_run", i), 16'(running),       16'(vecs[i].exp_run));
            checkOutput($sformatf("vec%0d_rdy", i), 16'(div_req_ready), 16'(vecs[i].exp_rdy));
            checkOutput($sformatf("vec%0d_cur", i), 16'(cur_div),       16'(vecs[i].exp_cur));
        end

        // Odd request 5: asymmetric 2/3 when honoured, otherwise forced to 4 and 2/2.
        measurePeriod("odd", int'(C5) / 2, int'(C5) - int'(C5) / 2);

        // Divisors 0 and 1 both coerce to 2.
        requestDiv(8'd0);
        waitPeriodStart("div0");
        checkOutput("div0_cur",   16'(cur_div),       16'd2);
        checkOutput("div0_ready", 16'(div_req_ready), 16'd1);
        requestDiv(8'd1);
        waitPeriodStart("div1");
        checkOutput("div1_cur", 16'(cur_div), 16'd2);
        measurePeriod("div2", 1, 1);

        // Stop: drop en in the second cycle of an N=8 period.
        requestDiv(8'd8);
        waitPeriodStart("div8");
        checkOutput("div8_cur",    16'(cur_div),     16'd8);
        checkOutput("stop_c1_clk", 16'(clk_div_out), 16'd1);
        tick();
        checkOutput("stop_c2_clk", 16'(clk_div_out), 16'd1);
        en      = 1'b0;
        high    = 2;
        low     = 0;
        stopped = 1'b0;
        for (int i = 0; i < 20 && !stopped; i++) begin
            tick();
            if (!running) stopped = 1'b1;
            else if (clk_div_out) high++;
            else low++;
        end
        checkOutput("stop_reached", 16'(stopped),      16'd1);
        checkOutput("stop_high",    16'(high),         16'd4);
        checkOutput("stop_low",     16'(low),          16'd4);
        checkOutput("stop_clk",     16'(clk_div_out),  16'd0);
        checkOutput("stop_ps",      16'(period_start), 16'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("stopped%0d_clk", i), 16'(clk_div_out), 16'd0);
            checkOutput($sformatf("stopped%0d_run", i), 16'(running),     16'd0);
        end

        // Update while stopped lands one edge after acceptance.
        div_req_valid = 1'b1;
        div_req_data  = 8'd6;
        tick();
        div_req_valid = 1'b0;
        checkOutput("stopreq_ready", 16'(div_req_ready), 16'd0);
        checkOutput("stopreq_cur0",  16'(cur_div),       16'd8);
        tick();
        checkOutput("stopreq_cur1",   16'(cur_div),       16'd6);
        checkOutput("stopreq_ready1", 16'(div_req_ready), 16'd1);

        en = 1'b1;
        tick();
        checkOutput("restart_clk", 16'(clk_div_out),  16'd1);
        checkOutput("restart_run", 16'(running),      16'd1);
        checkOutput("restart_ps",  16'(period_start), 16'd1);
        measurePeriod("div6", 3, 3);

        // Reset in the high phase with a divisor pending.
        requestDiv(8'd4);
        checkOutput("prereset_clk", 16'(clk_div_out), 16'd1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_clk",   16'(clk_div_out),   16'd0);
        checkOutput("midrst_ready", 16'(div_req_ready), 16'd1);
        checkOutput("midrst_run",   16'(running),       16'd0);
        checkOutput("midrst_cur",   16'(cur_div),       16'd2);
        en    = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("postrst%0d_run", i), 16'(running),     16'd0);
            checkOutput($sformatf("postrst%0d_clk", i), 16'(clk_div_out), 16'd0);
        end
        en = 1'b1;
        tick();
        checkOutput("rerun_clk", 16'(clk_div_out), 16'd1);
        checkOutput("rerun_run", 16'(running),     16'd1);
        measurePeriod("rerun", 1, 1);
        checkOutput("rerun_cur", 16'(cur_div), 16'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
